// File: rtl/qam16_symbol_mapper.sv
// Streaming 16-QAM mapper: valid/ready symbol FIFO, Gray I/Q level map, SPS samples per symbol.
// Optional build macro QAM_MAPPER_ZERO_STUFF_EN: zero-insertion upsampling instead of sample-and-hold.
module qam16_symbol_mapper #(
    parameter int                 SPS        = 4,
    parameter logic signed [15:0] AMP        = 16'sd8192,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    sym_in,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    output logic [31:0]                   iq_out,
    output logic                          iq_valid,
    input  logic                          iq_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   sym_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0]  LAST_PHASE = 4'(SPS - 1);
    localparam logic [15:0] LVL_P1 = AMP;
    localparam logic [15:0] LVL_P3 = 16'(3 * AMP);
    localparam logic [15:0] LVL_N1 = 16'(-AMP);
    localparam logic [15:0] LVL_N3 = 16'(-3 * AMP);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    phase_q;
    logic [3:0]    phase_d;
    logic [31:0]   iq_q;
    logic [31:0]   iq_d;
    logic          valid_q;
    logic          valid_d;
    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;

    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [3:0]    head_sym;

    // Gray coding per axis: adjacent levels differ in exactly one bit.
    function automatic logic [15:0] level_of(input logic [1:0] bits);
        logic [15:0] lvl;
        case (bits)
            2'b00:   lvl = LVL_N3;
            2'b01:   lvl = LVL_N1;
            2'b11:   lvl = LVL_P1;
            default: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

    function automatic logic [31:0] map_sym(input logic [3:0] s);
        return {level_of(s[3:2]), level_of(s[1:0])};
    endfunction

    assign sym_ready  = (level_q < LW'(FIFO_DEPTH));
    assign push       = sym_valid && sym_ready;
    assign fifo_empty = (level_q == '0);
    assign head_sym   = mem_q[rd_ptr_q];

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sym_in;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        iq_d    = iq_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    iq_d    = map_sym(head_sym);
                    phase_d = '0;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            default: begin
                if (valid_q && iq_ready) begin
                    if (phase_q == LAST_PHASE) begin
                        cnt_d   = cnt_q + 1'b1;
                        phase_d = '0;
                        // Back-to-back reload keeps the sample stream gap-free.
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            iq_d = map_sym(head_sym);
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
`ifdef QAM_MAPPER_ZERO_STUFF_EN
                        iq_d    = '0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            iq_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            iq_q    <= iq_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign iq_out     = iq_q;
    assign iq_valid   = valid_q;
    assign fifo_level = level_q;
    assign sym_count  = cnt_q;

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// Directed bench for qam16_symbol_mapper with an expected-beat scoreboard.
// Honours QAM_MAPPER_ZERO_STUFF_EN when the build defines it.
module tb_qam16_symbol_mapper;

    localparam int SPS        = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sym_in = 4'h0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [31:0] iq_out;
    logic        iq_valid;
    logic        iq_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic [15:0] sym_count;

    qam16_symbol_mapper #(
        .SPS        (SPS),
        .AMP        (16'sd8192),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .iq_out     (iq_out),
        .iq_valid   (iq_valid),
        .iq_ready   (iq_ready),
        .fifo_level (fifo_level),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          check_cnt = 0;
    int          fail_cnt = 0;
    logic [31:0] exp_q [$];
    int          beats_in_test = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          cyc = 0;
    int          ready_mode = 1;
    int          exp_syms = 0;

    function automatic logic [15:0] ref_level(input logic [1:0] b);
        case (b)
            2'b00:   return 16'hA000;
            2'b01:   return 16'hE000;
            2'b11:   return 16'h2000;
            default: return 16'h6000;
        endcase
    endfunction

    function automatic logic [31:0] ref_map(input logic [3:0] s);
        return {ref_level(s[3:2]), ref_level(s[1:0])};
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic queue_symbol(input logic [3:0] s);
        for (int k = 0; k < SPS; k++) begin
`ifdef QAM_MAPPER_ZERO_STUFF_EN
            exp_q.push_back(k == 0 ? ref_map(s) : 32'h0);
`else
            exp_q.push_back(ref_map(s));
`endif
        end
        exp_syms++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_sym(input logic [3:0] s, input int tmo, output bit acc);
        acc       = 1'b0;
        sym_in    = s;
        sym_valid = 1'b1;
        for (int t = 0; t < tmo && !acc; t++) begin
            if (sym_ready) begin
                acc = 1'b1;
                queue_symbol(s);
                $display("push sym=%h expect=%08h t=%0t", s, ref_map(s), $time);
            end
            @(posedge clk);
            #1;
        end
        sym_valid = 1'b0;
    endtask

    task automatic drain(input int tmo);
        bit done;
        done = 1'b0;
        for (int t = 0; t < tmo && !done; t++) begin
            if (exp_q.size() == 0 && !iq_valid) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check32("drain_done", 32'(done), 32'd1);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Sole driver of iq_ready; updates at posedge+2 so stimulus at +1 never races it.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       iq_ready = 1'b0;
            1:       iq_ready = 1'b1;
            default: iq_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && iq_valid && iq_ready) begin
            if (exp_q.size() == 0) begin
                check32("unexpected_beat", 32'(iq_valid), 32'd0);
            end else begin
                check32("beat", iq_out, exp_q.pop_front());
                if (beats_in_test == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats_in_test++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          n_acc;
        logic [31:0] held;
        logic [3:0]  syms2 [3];
        logic [3:0]  syms3 [7];
        syms2[0] = 4'b0000; syms2[1] = 4'b0111; syms2[2] = 4'b1101;
        syms3[0] = 4'h1; syms3[1] = 4'h6; syms3[2] = 4'hB; syms3[3] = 4'hC;
        syms3[4] = 4'h3; syms3[5] = 4'h9; syms3[6] = 4'hE;

        // Reset state
        #12;
        check32("rst_iq_out", iq_out, 32'h0);
        check32("rst_iq_valid", 32'(iq_valid), 32'd0);
        check32("rst_sym_ready", 32'(sym_ready), 32'd1);
        check32("rst_fifo_level", 32'(fifo_level), 32'd0);
        check32("rst_sym_count", 32'(sym_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Single symbol, latency and SPS beats
        beats_in_test = 0;
        push_sym(4'b1010, 4, acc);
        check32("t1_accept", 32'(acc), 32'd1);
        check32("t1_valid_after_push", 32'(iq_valid), 32'd0);
        check32("t1_level_after_push", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        check32("t1_valid_latency", 32'(iq_valid), 32'd1);
        check32("t1_first_value", iq_out, 32'h6000_6000);
        drain(50);
        check32("t1_beats", 32'(beats_in_test), 32'(SPS));
        check32("t1_valid_low", 32'(iq_valid), 32'd0);
        check32("t1_sym_count", 32'(sym_count), 32'd1);

        // Back-to-back symbols, no gaps
        beats_in_test = 0;
        for (int i = 0; i < 3; i++) begin
            push_sym(syms2[i], 10, acc);
            check32("t2_accept", 32'(acc), 32'd1);
        end
        drain(100);
        check32("t2_beats", 32'(beats_in_test), 32'(3 * SPS));
        check32("t2_no_gap", 32'(last_cyc - first_cyc), 32'(3 * SPS - 1));
        check32("t2_sym_count", 32'(sym_count), 32'd4);

        // Output stalled: capacity is FIFO_DEPTH plus one
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        beats_in_test = 0;
        n_acc = 0;
        for (int i = 0; i < 7; i++) begin
            push_sym(syms3[i], 3, acc);
            if (acc) n_acc++;
        end
        check32("t3_accepted", 32'(n_acc), 32'(FIFO_DEPTH + 1));
        check32("t3_level_full", 32'(fifo_level), 32'(FIFO_DEPTH));
        check32("t3_ready_low", 32'(sym_ready), 32'd0);
        held = iq_out;
        check32("t3_held_value", held, ref_map(syms3[0]));
        repeat (5) begin @(posedge clk); #1; end
        check32("t3_stable", iq_out, ref_map(syms3[0]));
        check32("t3_valid_held", 32'(iq_valid), 32'd1);
        ready_mode = 1;
        drain(200);
        check32("t3_beats", 32'(beats_in_test), 32'(5 * SPS));

        // Random backpressure over 200 symbols
        ready_mode = 2;
        beats_in_test = 0;
        for (int i = 0; i < 200; i++) begin
            push_sym(4'($urandom_range(0, 15)), 300, acc);
            check32("t4_accept", 32'(acc), 32'd1);
        end
        drain(4000);
        ready_mode = 1;
        check32("t4_beats", 32'(beats_in_test), 32'(200 * SPS));
        check32("t4_sym_count", 32'(sym_count), 32'(16'(exp_syms)));

        // Reset mid-symbol with three symbols queued
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            push_sym(4'(i + 4), 3, acc);
            check32("t5_accept", 32'(acc), 32'd1);
        end
        @(posedge clk); #1;
        check32("t5_level", 32'(fifo_level), 32'd3);
        ready_mode = 1;
        repeat (2) begin @(posedge clk); #1; end
        ready_mode = 0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_syms = 0;
        check32("t5_rst_iq_out", iq_out, 32'h0);
        check32("t5_rst_iq_valid", 32'(iq_valid), 32'd0);
        check32("t5_rst_sym_ready", 32'(sym_ready), 32'd1);
        check32("t5_rst_fifo_level", 32'(fifo_level), 32'd0);
        check32("t5_rst_sym_count", 32'(sym_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 1;
        beats_in_test = 0;
        repeat (10) begin @(posedge clk); #1; end
        check32("t5_no_stale_beats", 32'(beats_in_test), 32'd0);
        check32("t5_no_stale_valid", 32'(iq_valid), 32'd0);
        check32("t5_level_empty", 32'(fifo_level), 32'd0);
        push_sym(4'b1010, 4, acc);
        check32("t5_accept_after", 32'(acc), 32'd1);
        drain(50);
        check32("t5_beats_after", 32'(beats_in_test), 32'(SPS));
        check32("t5_sym_count_after", 32'(sym_count), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
